ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

PS/2 host-to-device transmitter: the host-side send path of the PS/2 keyboard port. It sends one command byte per request, such as 0xED for set LEDs or 0xFF for reset, to the keyboard already read through `ps2_clk_in`/`ps2_data_in`. It drives the bidirectional PS/2 lines through open-drain enables and reports completion, device NAK or timeout. While it is active, `busy` tells the existing receive path to ignore the bus.

## Interface
- `INHIBIT_CYCLES`, default 5000: Clock cycles the host holds PS/2 clock low before the request (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 750000: maximum number of Clock cycles between device clock falling edges before the transfer is aborted (15 ms).
- `Clock` in, 1: system clock, 50 MHz in `EntradaClock`'s domain.
- `Reset` in, 1: asynchronous, active-high.
- `tx_valid` in, 1: request to send `tx_data`.
- `tx_data` in, 8: command byte.
- `tx_ready` out, 1: high only in IDLE.
- `ps2_clk_in` in, 1: raw PS/2 clock pin level (asynchronous).
- `ps2_data_in` in, 1: raw PS/2 data pin level (asynchronous).
- `ps2_clk_oe` out, 1: 1 pulls the PS/2 clock low; 0 releases it to high-Z.
- `ps2_data_oe` out, 1: 1 pulls PS/2 data low; 0 releases it.
- `busy` out, 1: high in every state except IDLE.
- `tx_done` out, 1: one-cycle pulse on a successful, ACKed transfer.
- `tx_err` out, 1: one-cycle pulse on a failed transfer.
- `err_code` out, 2: 01 = NAK, 10 = timeout. It is held until the next accepted request, which clears it to 00.

## Operation
- Both raw pins are passed through a 2-flop synchronizer that resets to 1 (idle bus). `fall` is a 1-cycle strobe raised when the synchronized clock goes 1→0.
- **Accepting a request:** `tx_valid & tx_ready` latches `tx_data` and computes `par = ~^tx_data` (odd parity). It then clears `err_code`, sets `bit_idx = 0` and enters INHIBIT.
- **INHIBIT:** `clk_oe = 1`, `data_oe = 0` for exactly INHIBIT_CYCLES cycles, then go to START.
- **START:** for one cycle, `clk_oe = 1` and `data_oe = 1` (start bit 0). Then go to SHIFT with `clk_oe = 0`, keeping `data_oe = 1`.
- **SHIFT:** on each `fall`, drive the next bit with `data_oe = ~bit`.
  - `bit_idx` 0–7 carries `tx_data[bit_idx]`, LSB first.
  - `bit_idx` 8 carries `par`.
  - `bit_idx` 9 is the stop bit: `data_oe = 0`.
  - After the `fall` that drives the stop bit, go to ACK.
- **ACK:** on the next `fall`, sample synchronized data. A 0 goes to WAIT_IDLE. A 1 releases the bus, pulses `tx_err` with `err_code = 01`, and goes to IDLE.
- **WAIT_IDLE:** wait until synchronized clock and data are both 1, then go to DONE.
- **DONE:** pulse `tx_done` for one cycle, then go to IDLE.
- **Timeout:** the counter is cleared on entry to START and on every `fall`, and increments otherwise in SHIFT, ACK and WAIT_IDLE. When it reaches TIMEOUT_CYCLES−1: set both enables to 0, pulse `tx_err` with `err_code = 10`, go to IDLE.
- **Ignored input:** a new `tx_valid` while `busy` has no effect and is not queued.
- **Reset mid-transfer:** both enables go to 0 immediately (asynchronous), state goes to IDLE, and no `tx_done`/`tx_err` is generated.

## Timing
- **Reset values:**
  - Outputs: `ps2_clk_oe = 0`, `ps2_data_oe = 0`, `busy = 0`, `tx_done = 0`, `tx_err = 0`, `err_code = 00`, `tx_ready = 1`.
  - Synchronizers: both reset to 1.
- All outputs are registered except `tx_ready` and `busy`, which are decoded from the state register.
- **Request to bus:** `ps2_clk_oe` rises on the cycle after acceptance.
- **Inhibit and start:** `clk_oe` stays low for INHIBIT_CYCLES+1 cycles in total, with the data line already low during the last of those cycles.
- **Edge latency:** pin edge to `fall` is 3 Clock cycles. The data change lands 1 cycle after `fall`, which is well inside the device's clock-low half-period (≥30 µs).
- **Simultaneous events:** if a `fall` occurs on the same cycle the counter hits its limit, the `fall` wins and the counter clears.
- **Counters:** the counter is `$clog2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1)` bits wide and is shared between INHIBIT and timeout. `bit_idx` is 4 bits.

## Structure
- **`ps2_pkg`:**
  - State enum: IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE, DONE.
  - Error codes: `ERR_NONE = 00`, `ERR_NAK = 01`, `ERR_TIMEOUT = 10`.
  - `PS2_FRAME_BITS = 11`.
- **`ps2_line_sync` sub-module:** 2-flop synchronizer plus falling-edge strobe, reset to 1. It is reused by the receive path.
- **Top-level hookup:** each pin is driven as `oe ? 0 : Z`.

## Test plan
The bench uses INHIBIT_CYCLES = 20, TIMEOUT_CYCLES = 200 and a device model with a 10-cycle clock half-period.

- **Send 0xED:**
  - Stimulus: send 0xED; the device samples on rising edges and ACKs.
  - Required response: clock held low for 21 cycles; sampled bits 0,1,0,1,1,0,1,1,1,1,1 (start, data LSB first, parity 1, stop); `tx_done` pulses once; `err_code = 00`.
- **Send 0x01:** the parity bit sampled is 0. Send 0xFF: the parity bit sampled is 1.
- **NAK:** the device leaves data high in the ACK slot → `tx_err` pulses once, `err_code = 01`, both enables 0, `tx_ready = 1`.
- **Device silence:** the device never clocks after START → `tx_err` pulses 200 cycles after START, `err_code = 10`, bus released.
- **Busy and reset:** a second `tx_valid` during SHIFT is ignored and only one frame appears on the bus. Asserting `Reset` at `bit_idx = 4` drops both enables within the same cycle, with no done/err pulse and `tx_ready = 1`.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 types and constants for the host-side transmit and receive paths.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_START     = 3'd2,
    S_SHIFT     = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5,
    S_DONE      = 3'd6
  } ps2_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_NAK     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned PS2_BIT_IDX_W  = 4;

  // Bit index of the stop bit within the host-driven part of the frame (data 0-7, parity 8).
  localparam logic [PS2_BIT_IDX_W-1:0] PS2_STOP_IDX = PS2_BIT_IDX_W'(PS2_FRAME_BITS - 2);
  localparam logic [PS2_BIT_IDX_W-1:0] PS2_PAR_IDX  = PS2_BIT_IDX_W'(PS2_FRAME_BITS - 3);

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pins, idle-high on reset,
// with a registered one-cycle strobe on each falling edge of the clock line.
module ps2_line_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clk_pin,
  input  logic i_data_pin,
  output logic o_clk_level,
  output logic o_data_level,
  output logic o_clk_fall
);

  logic r_clk_meta;
  logic r_clk_sync;
  logic r_clk_prev;
  logic r_clk_fall;
  logic r_data_meta;
  logic r_data_sync;

  // Pin edge to strobe is three cycles: meta, sync, then the registered compare.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_clk_meta  <= 1'b1;
      r_clk_sync  <= 1'b1;
      r_clk_prev  <= 1'b1;
      r_clk_fall  <= 1'b0;
      r_data_meta <= 1'b1;
      r_data_sync <= 1'b1;
    end else begin
      r_clk_meta  <= i_clk_pin;
      r_clk_sync  <= r_clk_meta;
      r_clk_prev  <= r_clk_sync;
      r_clk_fall  <= r_clk_prev & ~r_clk_sync;
      r_data_meta <= i_data_pin;
      r_data_sync <= r_data_meta;
    end
  end

  assign o_clk_level  = r_clk_sync;
  assign o_data_level = r_data_sync;
  assign o_clk_fall   = r_clk_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, shift out
// one byte with odd parity on device clock edges, then check the device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                      : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_state_e                 r_state;
  logic [CNT_W-1:0]           r_cnt;
  logic [PS2_BIT_IDX_W-1:0]   r_bit_idx;
  logic [7:0]                 r_data;
  logic                       r_par;
  logic                       r_clk_oe;
  logic                       r_data_oe;
  logic                       r_done;
  logic                       r_err;
  logic [1:0]                 r_err_code;

  logic w_clk_lvl;
  logic w_data_lvl;
  logic w_fall;
  logic w_tx_bit;
  logic w_timeout;

  ps2_line_sync u_sync (
    .i_clk        (Clock),
    .i_rst        (Reset),
    .i_clk_pin    (ps2_clk_in),
    .i_data_pin   (ps2_data_in),
    .o_clk_level  (w_clk_lvl),
    .o_data_level (w_data_lvl),
    .o_clk_fall   (w_fall)
  );

  // Bit driven after the next device clock fall; the stop slot releases data.
  always_comb begin
    w_tx_bit = 1'b1;
    if (r_bit_idx < PS2_PAR_IDX) begin
      w_tx_bit = r_data[r_bit_idx[2:0]];
    end else if (r_bit_idx == PS2_PAR_IDX) begin
      w_tx_bit = r_par;
    end
  end

  assign w_timeout = (r_cnt == TIMEOUT_LAST);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_data     <= '0;
      r_par      <= 1'b0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (tx_valid) begin
            r_data     <= tx_data;
            r_par      <= odd_parity(tx_data);
            r_err_code <= ERR_NONE;
            r_bit_idx  <= '0;
            r_cnt      <= '0;
            r_clk_oe   <= 1'b1;
            r_data_oe  <= 1'b0;
            r_state    <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (r_cnt == INHIBIT_LAST) begin
            r_cnt     <= '0;
            r_data_oe <= 1'b1;
            r_state   <= S_START;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        // Start bit is already on the line; releasing the clock hands control to the device.
        S_START: begin
          r_clk_oe <= 1'b0;
          r_state  <= S_SHIFT;
        end

        S_SHIFT: begin
          if (w_fall) begin
            r_cnt     <= '0;
            r_data_oe <= ~w_tx_bit;
            r_bit_idx <= r_bit_idx + PS2_BIT_IDX_W'(1);
            if (r_bit_idx == PS2_STOP_IDX) begin
              r_state <= S_ACK;
            end
          end else if (w_timeout) begin
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_err      <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_ACK: begin
          if (w_fall) begin
            r_cnt <= '0;
            if (!w_data_lvl) begin
              r_state <= S_WAIT_IDLE;
            end else begin
              r_clk_oe   <= 1'b0;
              r_data_oe  <= 1'b0;
              r_err      <= 1'b1;
              r_err_code <= ERR_NAK;
              r_state    <= S_IDLE;
            end
          end else if (w_timeout) begin
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_err      <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_WAIT_IDLE: begin
          if (w_clk_lvl && w_data_lvl) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_fall) begin
            r_cnt <= '0;
          end else if (w_timeout) begin
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_err      <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_ready    = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign tx_done     = r_done;
  assign tx_err      = r_err;
  assign err_code    = r_err_code;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with an open-drain bus and a PS/2 device model.
module tb_ps2_host_tx;

  localparam int unsigned INH = 20;
  localparam int unsigned TMO = 200;
  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       tx_done;
  logic       tx_err;
  logic [1:0] err_code;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_pin;
  logic       ps2_data_pin;

  // Wired-AND bus: anyone pulling low wins, otherwise the pull-up holds it high.
  assign ps2_clk_pin  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_pin = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .Clock       (clk),
    .Reset       (rst),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_pin),
    .ps2_data_in (ps2_data_pin),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .err_code    (err_code)
  );

  typedef struct {
    logic       is_err;
    logic [1:0] code;
    int         shift_cyc;
  } out_t;

  out_t        exp_out_q[$];
  logic [10:0] exp_frame_q[$];
  int          exp_inh_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outcome monitor: pops an expectation on every done/err pulse.
  int   shift_cyc = 0;
  logic prev_pulse = 1'b0;
  always @(negedge clk) begin
    out_t e;
    if (tx_done || tx_err) begin
      chk("pulse_width", 32'(prev_pulse), 32'd0);
      if (exp_out_q.size() == 0) begin
        chk("unexpected_pulse", {tx_done, tx_err}, 32'd0);
      end else begin
        e = exp_out_q.pop_front();
        chk("outcome_is_err", 32'(tx_err), 32'(e.is_err));
        chk("outcome_done", 32'(tx_done), 32'(!e.is_err));
        chk("err_code", 32'(err_code), 32'(e.code));
        if (e.is_err) begin
          chk("err_clk_oe", 32'(ps2_clk_oe), 32'd0);
          chk("err_data_oe", 32'(ps2_data_oe), 32'd0);
          chk("err_tx_ready", 32'(tx_ready), 32'd1);
        end
        if (e.shift_cyc >= 0) chk("timeout_cycles", 32'(shift_cyc), 32'(e.shift_cyc));
      end
    end
    prev_pulse = tx_done | tx_err;
    if (ps2_clk_oe) shift_cyc = 0;
    else if (busy) shift_cyc++;
  end

  // Inhibit monitor: length of each clock-low run and start-bit overlap at its end.
  int   inh_run = 0;
  int   inh_dcnt = 0;
  logic inh_last_d = 1'b0;
  always @(negedge clk) begin
    if (ps2_clk_oe) begin
      inh_run++;
      if (ps2_data_oe) inh_dcnt++;
      inh_last_d = ps2_data_oe;
    end else if (inh_run > 0) begin
      if (exp_inh_q.size() == 0) chk("unexpected_inhibit", 32'(inh_run), 32'd0);
      else chk("inhibit_len", 32'(inh_run), 32'(exp_inh_q.pop_front()));
      chk("start_overlap", {inh_dcnt[30:0], inh_last_d}, {31'd1, 1'b1});
      inh_run  = 0;
      inh_dcnt = 0;
    end
  end

  // Device model. mode 0: ACK, 1: NAK, 2: silent, 3: stop after four clocks.
  task automatic device(input int mode);
    logic [10:0] got;
    int t;
    int n;
    got = '0;
    t = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("rts_seen", 32'(t < 1000), 32'd1);
    if (mode != 2) begin
      repeat (HALF) @(negedge clk);
      got[0] = ps2_data_pin;
      n = (mode == 3) ? 4 : 10;
      for (int i = 1; i <= n; i++) begin
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        got[i] = ps2_data_pin;
        repeat (HALF) @(negedge clk);
      end
      if (mode != 3) begin
        if (exp_frame_q.size() == 0) chk("unexpected_frame", 32'(got), 32'h7ff);
        else chk("frame_bits", 32'(got), 32'(exp_frame_q.pop_front()));
        dev_data_low = (mode == 0);
        dev_clk_low  = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low  = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        dev_data_low = 1'b0;
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    while (!tx_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("ready_before_send", 32'(tx_ready), 32'd1);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("clk_oe_after_accept", 32'(ps2_clk_oe), 32'd1);
    chk("err_cleared", 32'(err_code), 32'd0);
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!tx_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("return_to_idle", 32'(tx_ready), 32'd1);
    repeat (10) @(negedge clk);
  endtask

  task automatic expect_xfer(input logic [10:0] frame, input logic is_err,
                             input logic [1:0] code, input int cyc);
    out_t e;
    e.is_err    = is_err;
    e.code      = code;
    e.shift_cyc = cyc;
    exp_inh_q.push_back(INH + 1);
    if (frame != 11'h000) exp_frame_q.push_back(frame);
    exp_out_q.push_back(e);
  endtask

  initial begin
    int cnt;
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_err", {tx_done, tx_err}, 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 0xED: parity 1, device ACKs.
    expect_xfer({1'b1, 1'b1, 8'hED, 1'b0}, 1'b0, 2'b00, -1);
    fork send(8'hED); device(0); join
    wait_ready();
    chk("ed_err_code", 32'(err_code), 32'd0);

    // 0x01: parity 0.
    expect_xfer({1'b1, 1'b0, 8'h01, 1'b0}, 1'b0, 2'b00, -1);
    fork send(8'h01); device(0); join
    wait_ready();

    // 0xFF: parity 1.
    expect_xfer({1'b1, 1'b1, 8'hFF, 1'b0}, 1'b0, 2'b00, -1);
    fork send(8'hFF); device(0); join
    wait_ready();

    // NAK on 0xF4 (parity 0).
    expect_xfer({1'b1, 1'b0, 8'hF4, 1'b0}, 1'b1, 2'b01, -1);
    fork send(8'hF4); device(1); join
    wait_ready();
    chk("nak_code_held", 32'(err_code), 32'd1);

    // Silent device: timeout after TMO cycles of released clock.
    expect_xfer(11'h000, 1'b1, 2'b10, int'(TMO));
    fork send(8'h55); device(2); join
    wait_ready();
    chk("tmo_code_held", 32'(err_code), 32'd2);
    chk("tmo_bus_released", {ps2_clk_oe, ps2_data_oe}, 32'd0);

    // Request while busy is dropped; only one frame (0x3C, parity 1) appears.
    expect_xfer({1'b1, 1'b1, 8'h3C, 1'b0}, 1'b0, 2'b00, -1);
    fork
      device(0);
      begin
        send(8'h3C);
        repeat (60) @(negedge clk);
        chk("busy_in_shift", 32'(busy), 32'd1);
        tx_valid = 1'b1;
        tx_data  = 8'h81;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    wait_ready();
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ps2_clk_oe || busy) cnt++;
    end
    chk("no_queued_frame", 32'(cnt), 32'd0);

    // Reset with bit index 4 in flight (0xA5: bit 3 is 0, so data is pulled low).
    exp_inh_q.push_back(INH + 1);
    fork send(8'hA5); device(3); join
    repeat (5) @(negedge clk);
    chk("pre_rst_data_oe", 32'(ps2_data_oe), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_enables", {ps2_clk_oe, ps2_data_oe}, 32'd0);
    chk("rst_mid_ready", 32'(tx_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx_done || tx_err || busy) cnt++;
    end
    chk("rst_no_pulse", 32'(cnt), 32'd0);

    repeat (20) @(negedge clk);
    chk("out_q_drained", 32'(exp_out_q.size()), 32'd0);
    chk("frame_q_drained", 32'(exp_frame_q.size()), 32'd0);
    chk("inh_q_drained", 32'(exp_inh_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
